sif_mult_fp16_vec: RTL and testbench
====================================

// Module: sif_mult_fp16_vec
// PURPOSE
//  LANES-wide FP16 (1/5/10, bias 15) multiplier, native RTL with no vendor IP, behind the sif valid/ready stream handshake.
//  One A vector and one B vector are joined into one product vector per transfer, at one vector per cycle.
//  3-stage pipeline with per-stage stall that collapses bubbles. Selectable rounding mode; per-lane exception flags.
//  Used in the butterfly/NPU datapath wherever several FP16 products are formed together.
// PARAMETERS
//  LANES       4   number of independent FP16 lanes; lane i = bits [16*i+15:16*i]
//  ROUND_MODE  0   0 = round-to-nearest-even, 1 = truncate toward zero
// PORTS
//  clk     in   1         clock; all logic on rising edge
//  rst     in   1         synchronous, active-high reset
//  A_vld   in   1         A vector valid
//  A_dat   in   16*LANES  A operands
//  A_rdy   out  1         A accepted when A_vld&B_vld&A_rdy
//  B_vld   in   1         B vector valid
//  B_dat   in   16*LANES  B operands
//  B_rdy   out  1         always equal to A_rdy
//  P_vld   out  1         product vector valid
//  P_dat   out  16*LANES  products
//  P_exc   out  3*LANES   per lane {invalid, overflow, underflow}, aligned with P_dat
//  P_rdy   in   1         downstream ready
// BEHAVIOUR
//  Reset: while rst=1, A_rdy=B_rdy=0 and all stage valids clear. On the cycle after rst falls: P_vld=0, P_dat=0, P_exc=0, A_rdy=B_rdy=1.
//  Join: an input fires only when A_vld&B_vld&A_rdy. If only one side is valid, nothing is consumed.
//  A_rdy/B_rdy depend only on pipeline state, never on A_vld/B_vld.
//  Stages S1 (unpack, 11x11 mantissa product, exponent sum), S2 (normalise, round), S3 (special-case select, pack, output register).
//  Each stage register k loads when !vld_k | rdy_(k+1); rdy_out = P_rdy; A_rdy = !vld_S1 | rdy_S1.
//  Latency: with P_rdy=1, fire at cycle t -> P_vld=1 with that result at t+3. Throughput 1/cycle.
//  Backpressure: while P_vld&!P_rdy, P_dat/P_exc are held stable. Bubbles ahead of the stall are filled.
//  With all 3 stages full and P_rdy=0, A_rdy=0.
//  Ordering: strict FIFO order; no drop, no duplication.
//  Arithmetic, per lane, sign always = sA^sB:
//   - subnormal input (exp=0, frac!=0): flushed to zero; no flag.
//   - either input NaN -> 0x7E00, invalid=1. Inf*0 -> 0x7E00, invalid=1.
//   - Inf*finite nonzero, or Inf*Inf -> signed Inf (0x7C00|sign<<15); no flag.
//   - zero*finite -> signed zero; no flag.
//   - normal*normal: exp = eA+eB-15, plus 1 if product >= 2.0.
//     Round at 10 fraction bits using guard and sticky bits; a rounding carry renormalises.
//   - final exp >= 31 -> signed Inf, overflow=1.
//   - final exp <= 0 -> signed zero (FTZ), underflow=1.
//  ROUND_MODE=1 drops the guard/sticky bits; overflow then still yields Inf.
//  Reset mid-operation: all in-flight vectors are discarded. No P_vld is produced for them after reset.
//  Simultaneous fire and output pop in one cycle is legal and keeps full throughput.
// TESTING
//  1. lane0 0x3C00*0x4000, lane1 0x3E00*0x3E00, P_rdy=1 -> P_vld at t+3; lane0 0x4000, lane1 0x4080, P_exc=0.
//  2. lane0 0x3C05*0x3E00 -> RNE: 0x3E08; ROUND_MODE=1 build: 0x3E07.
//     lane1 0x3C03*0x3E00 -> 0x3E04 in both modes (tie to even).
//  3. Specials:
//     - 0x7BFF*0x7BFF -> 0x7C00, overflow=1
//     - 0x7C00*0x0000 -> 0x7E00, invalid=1
//     - 0x0400*0x0400 -> 0x0000, underflow=1
//     - 0x8001*0x3C00 -> 0x0000 (sign 1 -> 0x8000), no flag
//  4. Stream 20 vectors with A_vld/B_vld toggled independently and P_rdy random.
//     -> exactly the jointly-valid vectors emerge, in order, with P_dat stable during stalls.
//  5. P_rdy=0 for 10 cycles while streaming -> exactly 3 vectors accepted, then A_rdy=0.
//     P_rdy=1 -> one result per cycle, A_rdy=1 the same cycle.
//  6. Pipeline full, assert rst 1 cycle -> next cycle P_vld=0, P_dat=0; A_rdy=1 after rst falls; no stale output.

Source files
------------

// File: rtl/sif_mult_fp16_vec.sv
// LANES-wide FP16 multiplier behind a joined A/B valid-ready stream; latency 3 cycles, 1 vector/cycle.
// Backpressure: per-stage stall collapses bubbles; output held while P_vld & !P_rdy, A_rdy low only when all stages are full.
module sif_mult_fp16_vec #(
  parameter int LANES      = 4,
  parameter int ROUND_MODE = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                A_vld,
  input  logic [16*LANES-1:0] A_dat,
  output logic                A_rdy,
  input  logic                B_vld,
  input  logic [16*LANES-1:0] B_dat,
  output logic                B_rdy,
  output logic                P_vld,
  output logic [16*LANES-1:0] P_dat,
  output logic [3*LANES-1:0]  P_exc,
  input  logic                P_rdy
);

  localparam logic [1:0] CLS_NORM = 2'd0;
  localparam logic [1:0] CLS_ZERO = 2'd1;
  localparam logic [1:0] CLS_INF  = 2'd2;
  localparam logic [1:0] CLS_NAN  = 2'd3;

  typedef struct packed {
    logic        sign;
    logic [1:0]  cls;
    logic [7:0]  exp;   // two's complement, unbiased-by-one-bias sum
    logic [21:0] prod;
  } s1_t;

  typedef struct packed {
    logic       sign;
    logic [1:0] cls;
    logic [7:0] exp;
    logic [9:0] frac;
  } s2_t;

  function automatic s1_t f_s1(input logic [15:0] a, input logic [15:0] b);
    s1_t         r;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [21:0] ma, mb;
    a_zero = (a[14:10] == 5'd0);
    b_zero = (b[14:10] == 5'd0);
    a_inf  = (a[14:10] == 5'h1f) && (a[9:0] == 10'd0);
    b_inf  = (b[14:10] == 5'h1f) && (b[9:0] == 10'd0);
    a_nan  = (a[14:10] == 5'h1f) && (a[9:0] != 10'd0);
    b_nan  = (b[14:10] == 5'h1f) && (b[9:0] != 10'd0);
    ma     = {11'd0, 1'b1, a[9:0]};
    mb     = {11'd0, 1'b1, b[9:0]};
    r.sign = a[15] ^ b[15];
    r.prod = ma * mb;
    r.exp  = {3'b000, a[14:10]} + {3'b000, b[14:10]} - 8'd15;
    // Subnormals have exp==0, so they fall into the zero class (flush).
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
      r.cls = CLS_NAN;
    else if (a_inf || b_inf)
      r.cls = CLS_INF;
    else if (a_zero || b_zero)
      r.cls = CLS_ZERO;
    else
      r.cls = CLS_NORM;
    return r;
  endfunction

  function automatic s2_t f_s2(input s1_t s);
    s2_t         r;
    logic [9:0]  frac;
    logic        guard, sticky, inc;
    logic [7:0]  exp;
    logic [11:0] mant;
    if (s.prod[21]) begin
      frac   = s.prod[20:11];
      guard  = s.prod[10];
      sticky = |s.prod[9:0];
      exp    = s.exp + 8'd1;
    end else begin
      frac   = s.prod[19:10];
      guard  = s.prod[9];
      sticky = |s.prod[8:0];
      exp    = s.exp;
    end
    inc    = (ROUND_MODE == 0) && guard && (sticky || frac[0]);
    mant   = {2'b01, frac} + {11'd0, inc};
    r.sign = s.sign;
    r.cls  = s.cls;
    r.exp  = mant[11] ? exp + 8'd1 : exp;
    r.frac = mant[11] ? mant[10:1] : mant[9:0];
    return r;
  endfunction

  // Returns {invalid, overflow, underflow, fp16}.
  function automatic logic [18:0] f_s3(input s2_t s);
    logic [18:0] r;
    case (s.cls)
      CLS_NAN:  r = {3'b100, 16'h7E00};
      CLS_INF:  r = {3'b000, s.sign, 15'h7C00};
      CLS_ZERO: r = {3'b000, s.sign, 15'h0000};
      default: begin
        if ($signed(s.exp) >= 8'sd31)
          r = {3'b010, s.sign, 15'h7C00};
        else if ($signed(s.exp) <= 8'sd0)
          r = {3'b001, s.sign, 15'h0000};
        else
          r = {3'b000, s.sign, s.exp[4:0], s.frac};
      end
    endcase
    return r;
  endfunction

  logic        vld1, vld2;
  logic        en1, en2, en3, fire;
  s1_t         s1_q [LANES];
  s2_t         s2_q [LANES];
  s1_t         s1_d [LANES];
  s2_t         s2_d [LANES];
  logic [18:0] p_d  [LANES];

  assign en3   = !P_vld || P_rdy;
  assign en2   = !vld2 || en3;
  assign en1   = !vld1 || en2;
  assign A_rdy = !rst && en1;
  assign B_rdy = A_rdy;
  assign fire  = A_vld && B_vld && A_rdy;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      s1_d[i] = f_s1(A_dat[16*i +: 16], B_dat[16*i +: 16]);
      s2_d[i] = f_s2(s1_q[i]);
      p_d[i]  = f_s3(s2_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (fire)
        s1_q[i] <= s1_d[i];
      if (en2 && vld1)
        s2_q[i] <= s2_d[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld1  <= 1'b0;
      vld2  <= 1'b0;
      P_vld <= 1'b0;
      P_dat <= '0;
      P_exc <= '0;
    end else begin
      if (en1)
        vld1 <= fire;
      if (en2)
        vld2 <= vld1;
      if (en3)
        P_vld <= vld2;
      if (en3 && vld2) begin
        for (int i = 0; i < LANES; i++) begin
          P_dat[16*i +: 16] <= p_d[i][15:0];
          P_exc[3*i +: 3]   <= p_d[i][18:16];
        end
      end
    end
  end

endmodule

// File: tb/tb_sif_mult_fp16_vec.sv
// Drives a round-to-nearest and a truncating instance with identical streams and
// scores both against a real-arithmetic FP16 product model.
module tb_sif_mult_fp16_vec;

  localparam int L = 4;

  logic          clk;
  logic          rst;
  logic          A_vld, B_vld, P_rdy;
  logic [16*L-1:0] A_dat, B_dat;
  logic          A_rdy0, B_rdy0, P_vld0, A_rdy1, B_rdy1, P_vld1;
  logic [16*L-1:0] P_dat0, P_dat1;
  logic [3*L-1:0]  P_exc0, P_exc1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_fire = 0;
  int n_pop  = 0;
  int lat_last = 0;
  logic            stall_prev = 1'b0;
  logic [16*L-1:0] hold_dat;
  logic [3*L-1:0]  hold_exc;
  logic [16*L-1:0] pop_dat0, pop_dat1;
  logic [3*L-1:0]  pop_exc0, pop_exc1;

  logic [16*L-1:0] qd0[$], qd1[$];
  logic [3*L-1:0]  qe0[$], qe1[$];
  int              qt[$];

  sif_mult_fp16_vec #(.LANES(L), .ROUND_MODE(0)) dut_rne (
    .clk(clk), .rst(rst),
    .A_vld(A_vld), .A_dat(A_dat), .A_rdy(A_rdy0),
    .B_vld(B_vld), .B_dat(B_dat), .B_rdy(B_rdy0),
    .P_vld(P_vld0), .P_dat(P_dat0), .P_exc(P_exc0), .P_rdy(P_rdy)
  );

  sif_mult_fp16_vec #(.LANES(L), .ROUND_MODE(1)) dut_trn (
    .clk(clk), .rst(rst),
    .A_vld(A_vld), .A_dat(A_dat), .A_rdy(A_rdy1),
    .B_vld(B_vld), .B_dat(B_dat), .B_rdy(B_rdy1),
    .P_vld(P_vld1), .P_dat(P_dat1), .P_exc(P_exc1), .P_rdy(P_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // FP16 product from the value rules: exact real product, then rounding to 10 fraction bits.
  function automatic logic [18:0] ref_mul(input logic [15:0] a, input logic [15:0] b, input int mode);
    logic s, az, bz, ai, bi, an, bn;
    int   ea, eb, e, fl;
    real  m, sc, rem;
    s  = a[15] ^ b[15];
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    az = (ea == 0);
    bz = (eb == 0);
    ai = (ea == 31) && (a[9:0] == 10'd0);
    bi = (eb == 31) && (b[9:0] == 10'd0);
    an = (ea == 31) && (a[9:0] != 10'd0);
    bn = (eb == 31) && (b[9:0] != 10'd0);
    if (an || bn || (ai && bz) || (bi && az)) return {3'b100, 16'h7E00};
    if (ai || bi) return {3'b000, s, 15'h7C00};
    if (az || bz) return {3'b000, s, 15'h0000};
    m = (1.0 + real'(a[9:0]) / 1024.0) * (1.0 + real'(b[9:0]) / 1024.0);
    e = ea + eb - 15;
    while (m >= 2.0) begin
      m = m / 2.0;
      e++;
    end
    sc  = m * 1024.0;
    fl  = $rtoi(sc);
    rem = sc - real'(fl);
    if (mode == 0 && (rem > 0.5 || (rem == 0.5 && (fl % 2) == 1))) fl++;
    if (fl == 2048) begin
      fl = 1024;
      e++;
    end
    if (e >= 31) return {3'b010, s, 15'h7C00};
    if (e <= 0)  return {3'b001, s, 15'h0000};
    return {3'b000, s, e[4:0], fl[9:0]};
  endfunction

  task automatic push_expected(input logic [63:0] ad, input logic [63:0] bd);
    logic [16*L-1:0] d0, d1;
    logic [3*L-1:0]  e0, e1;
    logic [18:0]     r0, r1;
    for (int i = 0; i < L; i++) begin
      r0 = ref_mul(ad[16*i +: 16], bd[16*i +: 16], 0);
      r1 = ref_mul(ad[16*i +: 16], bd[16*i +: 16], 1);
      d0[16*i +: 16] = r0[15:0];
      e0[3*i +: 3]   = r0[18:16];
      d1[16*i +: 16] = r1[15:0];
      e1[3*i +: 3]   = r1[18:16];
    end
    qd0.push_back(d0); qe0.push_back(e0);
    qd1.push_back(d1); qe1.push_back(e1);
    qt.push_back(cyc);
  endtask

  // One clock of stimulus with full scoreboard / handshake checking.
  task automatic cycle(input logic av, input logic bv, input logic [63:0] ad,
                       input logic [63:0] bd, input logic pr);
    logic exp_rdy;
    @(negedge clk);
    A_vld = av; B_vld = bv; A_dat = ad; B_dat = bd; P_rdy = pr;
    #1;
    cyc++;
    exp_rdy = !(qd0.size() == 3 && !pr);
    check("a_rdy", A_rdy0, exp_rdy);
    check("b_rdy", B_rdy0, exp_rdy);
    check("a_rdy_trn", A_rdy1, exp_rdy);
    check("p_vld_trn", P_vld1, P_vld0);
    if (stall_prev) begin
      check("hold_vld", P_vld0, 1'b1);
      check("hold_dat", P_dat0, hold_dat);
      check("hold_exc", P_exc0, hold_exc);
    end
    if (qd0.size() == 0) begin
      check("spurious_vld", P_vld0, 1'b0);
    end else if (P_vld0) begin
      check("dat_rne", P_dat0, qd0[0]);
      check("exc_rne", P_exc0, qe0[0]);
      check("dat_trn", P_dat1, qd1[0]);
      check("exc_trn", P_exc1, qe1[0]);
      if (pr) begin
        pop_dat0 = P_dat0; pop_exc0 = P_exc0;
        pop_dat1 = P_dat1; pop_exc1 = P_exc1;
        lat_last = cyc - qt[0];
        void'(qd0.pop_front()); void'(qe0.pop_front());
        void'(qd1.pop_front()); void'(qe1.pop_front());
        void'(qt.pop_front());
        n_pop++;
      end
    end
    stall_prev = P_vld0 && !pr;
    hold_dat   = P_dat0;
    hold_exc   = P_exc0;
    if (av && bv && A_rdy0) begin
      push_expected(ad, bd);
      n_fire++;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 64'd0, 64'd0, 1'b1);
  endtask

  task automatic clear_model();
    qd0.delete(); qe0.delete(); qd1.delete(); qe1.delete(); qt.delete();
    stall_prev = 1'b0;
  endtask

  initial begin
    int n0, p0, acc, guard;
    rst = 1'b1; A_vld = 1'b0; B_vld = 1'b0; P_rdy = 1'b0;
    A_dat = '0; B_dat = '0;

    // Reset
    repeat (2) @(negedge clk);
    #1;
    check("rst_a_rdy", A_rdy0, 1'b0);
    check("rst_b_rdy", B_rdy0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_vld", P_vld0, 1'b0);
    check("post_rst_dat", P_dat0, 64'd0);
    check("post_rst_exc", P_exc0, 12'd0);
    check("post_rst_a_rdy", A_rdy0, 1'b1);
    check("post_rst_b_rdy", B_rdy0, 1'b1);

    // Basic products and latency
    cycle(1'b1, 1'b1, {16'h3C00, 16'h3C00, 16'h3E00, 16'h3C00},
                      {16'h3C00, 16'h4000, 16'h3E00, 16'h4000}, 1'b1);
    idle(4);
    check("latency", lat_last, 3);
    check("t1_lane0", pop_dat0[15:0], 16'h4000);
    check("t1_lane1", pop_dat0[31:16], 16'h4080);
    check("t1_exc", pop_exc0, 12'd0);

    // Rounding: RNE vs truncate, and a tie to even
    cycle(1'b1, 1'b1, {16'h3C00, 16'h3C00, 16'h3C03, 16'h3C05},
                      {16'h3C00, 16'h3C00, 16'h3E00, 16'h3E00}, 1'b1);
    idle(4);
    check("rne_lane0", pop_dat0[15:0], 16'h3E08);
    check("trn_lane0", pop_dat1[15:0], 16'h3E07);
    check("rne_tie", pop_dat0[31:16], 16'h3E04);
    check("trn_tie", pop_dat1[31:16], 16'h3E04);

    // Special cases
    cycle(1'b1, 1'b1, {16'h8001, 16'h0400, 16'h7C00, 16'h7BFF},
                      {16'h3C00, 16'h0400, 16'h0000, 16'h7BFF}, 1'b1);
    idle(4);
    check("spec_dat", pop_dat0, {16'h8000, 16'h0000, 16'h7E00, 16'h7C00});
    check("spec_exc", pop_exc0, {3'b000, 3'b001, 3'b100, 3'b010});
    check("spec_dat_trn", pop_dat1, {16'h8000, 16'h0000, 16'h7E00, 16'h7C00});

    // Random stream with independent valids and random P_rdy
    n0 = n_fire;
    guard = 0;
    while (n_fire - n0 < 20 && guard < 400) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      guard++;
    end
    check("stream_count", n_fire - n0, 20);
    guard = 0;
    while (qd0.size() != 0 && guard < 20) begin
      idle(1);
      guard++;
    end
    check("stream_drain", qd0.size(), 0);

    // Full stall: only three vectors fit, then release at full rate
    n0 = n_fire;
    for (int k = 0; k < 10; k++)
      cycle(1'b1, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
    check("stall_accept", n_fire - n0, 3);
    check("stall_a_rdy", A_rdy0, 1'b0);
    n0 = n_fire;
    p0 = n_pop;
    for (int k = 0; k < 5; k++)
      cycle(1'b1, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
    check("release_pops", n_pop - p0, 5);
    check("release_fires", n_fire - n0, 5);

    // Reset with a full pipeline
    cycle(1'b1, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
    @(negedge clk);
    rst = 1'b1; A_vld = 1'b0; B_vld = 1'b0; P_rdy = 1'b0;
    #1;
    check("midrst_a_rdy", A_rdy0, 1'b0);
    clear_model();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_vld", P_vld0, 1'b0);
    check("midrst_dat", P_dat0, 64'd0);
    check("midrst_exc", P_exc0, 12'd0);
    check("midrst_a_rdy_after", A_rdy0, 1'b1);
    acc = n_pop;
    idle(6);
    check("midrst_no_stale", n_pop - acc, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
